// File: rtl/count_ctrl.sv
// Push-button front-end for the 4-bit up/down counter: synchronise, debounce, edge-detect, run/step FSM.
// Optional auto-reverse on counter wrap is enabled by defining COUNT_CTRL_AUTO_REVERSE_EN.
module count_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run,
    input  logic       btn_step,
    input  logic       btn_dir,
    input  logic       overflow,
    input  logic       underflow,
    output logic       en,
    output logic       up_down,
    output logic [1:0] state
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    // bit 0 = run, bit 1 = step, bit 2 = dir
    logic [2:0]    btn_raw;
    logic [2:0]    sync1_q, sync2_q;
    logic [2:0]    stable_q, stable_d;
    logic [2:0]    stable_dly_q;
    logic [2:0]    press;
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];

    state_t state_q, state_d;
    logic   en_q, en_d;
    logic   up_q, up_d;

    assign btn_raw = {btn_dir, btn_step, btn_run};
    assign press   = stable_q & ~stable_dly_q;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cnt_d[i]    = '0;
            stable_d[i] = stable_q[i];
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q      <= btn_raw;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP: begin
                if (press[0]) begin
                    state_d = ST_RUN;
                end else if (press[1]) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                if (press[0]) begin
                    state_d = ST_STOP;
                end
            end
            ST_STEP: state_d = ST_STOP;
            default: state_d = ST_STOP;
        endcase

        en_d = (state_d == ST_RUN) || (state_d == ST_STEP);

        up_d = up_q;
`ifdef COUNT_CTRL_AUTO_REVERSE_EN
        // A wrap reversal wins over a coincident dir press, which is dropped.
        if (en_q && up_q && overflow) begin
            up_d = 1'b0;
        end else if (en_q && !up_q && underflow) begin
            up_d = 1'b1;
        end else if (press[2]) begin
            up_d = ~up_q;
        end
`else
        if (press[2]) begin
            up_d = ~up_q;
        end
`endif
    end

`ifndef COUNT_CTRL_AUTO_REVERSE_EN
    logic unused_flags;
    assign unused_flags = overflow | underflow;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_STOP;
            en_q    <= 1'b0;
            up_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            up_q    <= up_d;
        end
    end

    assign en      = en_q;
    assign up_down = up_q;
    assign state   = state_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Scoreboard bench for count_ctrl: directed button scenarios plus random button/flag traffic
// checked against a window-based debounce model.
module tb_count_ctrl;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_run = 1'b0, btn_step = 1'b0, btn_dir = 1'b0;
    logic       overflow = 1'b0, underflow = 1'b0;
    logic       en, up_down;
    logic [1:0] state;

    count_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_run   (btn_run),
        .btn_step  (btn_step),
        .btn_dir   (btn_dir),
        .overflow  (overflow),
        .underflow (underflow),
        .en        (en),
        .up_down   (up_down),
        .state     (state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_q [$];

    // Reference model: a button level is accepted once its last D synchronised
    // samples all disagree with the accepted level.
    bit hist [3][$];
    bit m_stable [3];
    bit m_press  [3];
    int m_state = 0;
    bit m_en = 1'b0;
    bit m_up = 1'b1;

    task automatic model_reset();
        m_state = 0;
        m_en    = 1'b0;
        m_up    = 1'b1;
        for (int b = 0; b < 3; b++) begin
            m_stable[b] = 1'b0;
            m_press[b]  = 1'b0;
            hist[b].delete();
            for (int k = 0; k <= D; k++) hist[b].push_back(1'b0);
        end
    endtask

    task automatic model_edge(input bit [2:0] raw, input bit ov, input bit un, input bit r);
        int ns;
        bit nup;
        bit all_diff;
        if (r) begin
            model_reset();
            return;
        end
        ns = m_state;
        if (m_state == 0) begin
            if (m_press[0]) ns = 1;
            else if (m_press[1]) ns = 2;
        end else if (m_state == 1) begin
            if (m_press[0]) ns = 0;
        end else begin
            ns = 0;
        end
        nup = m_up;
`ifdef COUNT_CTRL_AUTO_REVERSE_EN
        if (m_en && m_up && ov) nup = 1'b0;
        else if (m_en && !m_up && un) nup = 1'b1;
        else if (m_press[2]) nup = !m_up;
`else
        if (m_press[2]) nup = !m_up;
`endif
        m_state = ns;
        m_en    = (ns != 0);
        m_up    = nup;
        for (int b = 0; b < 3; b++) begin
            // hist[b][0..D-1] are the synchronised levels seen at the last D edges
            all_diff = 1'b1;
            for (int k = 0; k < D; k++) begin
                if (hist[b][k] == m_stable[b]) all_diff = 1'b0;
            end
            m_press[b] = 1'b0;
            if (all_diff) begin
                m_stable[b] = !m_stable[b];
                m_press[b]  = m_stable[b];
            end
            hist[b].push_back(raw[b]);
            void'(hist[b].pop_front());
        end
    endtask

    // raw = {dir, step, run}
    task automatic drive(input bit [2:0] raw, input bit ov, input bit un, input bit r, input int n);
        repeat (n) begin
            btn_run   = raw[0];
            btn_step  = raw[1];
            btn_dir   = raw[2];
            overflow  = ov;
            underflow = un;
            rst       = r;
            model_edge(raw, ov, un, r);
            exp_q.push_back({m_en, m_up, m_state[1:0]});
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [3:0] e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if ({en, up_down, state} !== e) begin
                    bad++;
                    $display("FAIL outputs t=%0t: got en=%b up_down=%b state=%0d, want en=%b up_down=%b state=%0d",
                             $time, en, up_down, state, e[3], e[2], e[1:0]);
                end
            end
        end
    end

    initial begin
        bit [2:0] btn;
        bit ov, un, r;
        model_reset();

        // reset with every button held, then a clean run press
        drive(3'b111, 1'b0, 1'b0, 1'b1, 2);
        drive(3'b000, 1'b0, 1'b0, 1'b0, 3);
        drive(3'b001, 1'b0, 1'b0, 1'b0, 10);
        drive(3'b000, 1'b0, 1'b0, 1'b0, 8);
        drive(3'b001, 1'b0, 1'b0, 1'b0, 8);
        drive(3'b000, 1'b0, 1'b0, 1'b0, 8);

        // glitch rejection, then two clean presses
        drive(3'b001, 1'b0, 1'b0, 1'b0, 2);
        drive(3'b000, 1'b0, 1'b0, 1'b0, 6);
        drive(3'b001, 1'b0, 1'b0, 1'b0, 3);
        drive(3'b000, 1'b0, 1'b0, 1'b0, 8);
        drive(3'b001, 1'b0, 1'b0, 1'b0, 8);
        drive(3'b000, 1'b0, 1'b0, 1'b0, 8);
        drive(3'b001, 1'b0, 1'b0, 1'b0, 8);
        drive(3'b000, 1'b0, 1'b0, 1'b0, 8);

        // single step from STOP, then step ignored while running
        drive(3'b010, 1'b0, 1'b0, 1'b0, 6);
        drive(3'b000, 1'b0, 1'b0, 1'b0, 8);
        drive(3'b001, 1'b0, 1'b0, 1'b0, 6);
        drive(3'b000, 1'b0, 1'b0, 1'b0, 8);
        drive(3'b010, 1'b0, 1'b0, 1'b0, 6);
        drive(3'b000, 1'b0, 1'b0, 1'b0, 8);
        drive(3'b001, 1'b0, 1'b0, 1'b0, 6);
        drive(3'b000, 1'b0, 1'b0, 1'b0, 8);

        // simultaneous run+step, then run+dir together
        drive(3'b011, 1'b0, 1'b0, 1'b0, 6);
        drive(3'b000, 1'b0, 1'b0, 1'b0, 8);
        drive(3'b001, 1'b0, 1'b0, 1'b0, 6);
        drive(3'b000, 1'b0, 1'b0, 1'b0, 8);
        drive(3'b101, 1'b0, 1'b0, 1'b0, 6);
        drive(3'b000, 1'b0, 1'b0, 1'b0, 8);

        // dir press cut short by reset mid-debounce
        drive(3'b100, 1'b0, 1'b0, 1'b0, 3);
        drive(3'b100, 1'b0, 1'b0, 1'b1, 2);
        drive(3'b000, 1'b0, 1'b0, 1'b0, 10);

        // auto-reverse: overflow while running up, then underflow on a dir press cycle
        drive(3'b001, 1'b0, 1'b0, 1'b0, 6);
        drive(3'b000, 1'b0, 1'b0, 1'b0, 4);
        drive(3'b000, 1'b1, 1'b0, 1'b0, 1);
        drive(3'b000, 1'b0, 1'b0, 1'b0, 3);
        drive(3'b100, 1'b0, 1'b0, 1'b0, 6);
        drive(3'b100, 1'b0, 1'b1, 1'b0, 1);
        drive(3'b100, 1'b0, 1'b0, 1'b0, 2);
        drive(3'b000, 1'b0, 1'b0, 1'b0, 8);
        drive(3'b000, 1'b0, 1'b1, 1'b0, 1);
        drive(3'b000, 1'b1, 1'b0, 1'b0, 1);
        drive(3'b000, 1'b0, 1'b0, 1'b0, 4);

        // random button bouncing, wrap flags and occasional resets
        btn = 3'b000;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(7) == 0) btn[b] = !btn[b];
            end
            ov = ($urandom_range(15) == 0);
            un = ($urandom_range(15) == 0);
            r  = ($urandom_range(299) == 0);
            drive(btn, ov, un, r, 1);
        end
        drive(3'b000, 1'b0, 1'b0, 1'b0, 4);

        repeat (3) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/count_ctrl.md
Name: count_ctrl

Overview:
- Control front-end that sits directly upstream of the 4-bit up/down counter and drives its `en` and `up_down` inputs.
- Takes three raw, asynchronous push-button inputs (run/stop, step, direction). It synchronises and debounces each one, then turns clean presses into single-cycle events.
- A small FSM uses those events to generate the counter controls.
- It also watches the counter's `overflow`/`underflow` flags for the optional auto-reverse feature.

Parameters:
- `DEBOUNCE_CYCLES`, 4: consecutive synchronised cycles a button level must hold before it is accepted. Must be ≥2. Debounce counter width is $clog2(DEBOUNCE_CYCLES)+1.

Ports:
- `clk`  input  1  system clock; all logic on rising edge
- `rst`  input  1  synchronous reset, active-high
- `btn_run`  input  1  raw run/stop button, asynchronous, active-high
- `btn_step`  input  1  raw single-step button, asynchronous, active-high
- `btn_dir`  input  1  raw direction-toggle button, asynchronous, active-high
- `overflow`  input  1  counter flag, high in the cycle the count wraps 15→0
- `underflow`  input  1  counter flag, high in the cycle the count wraps 0→15
- `en`  output  1  counter enable
- `up_down`  output  1  counter direction, 1 = up, 0 = down
- `state`  output  2  FSM state: 0 STOP, 1 RUN, 2 STEP

Behaviour:
- Reset: one clock and a synchronous active-high reset `rst`. When `rst`=1 at a rising edge, everything below is set on that edge, and `rst` overrides all other inputs that edge.
  - `en`=0, `up_down`=1, `state`=STOP.
  - Synchronisers and stable levels = 0; debounce counters = 0.
  - Reset mid-operation behaves the same: a press in progress is discarded.
- Per button, synchronise and debounce:
  - Two-flop synchroniser s1→s2.
  - Debounce counter: increments each edge while s2 ≠ stable; clears whenever s2 = stable.
  - On the edge where s2 ≠ stable and counter = DEBOUNCE_CYCLES-1: stable ← s2 and counter ← 0.
  - stable_d ← stable every edge. Press event = stable & ~stable_d, a one-cycle pulse.
  - Only rising presses generate events; releases are debounced but produce no event.
- Latency: raw rises before edge E and stays high. Press pulse is high in the cycle after edge E+1+DEBOUNCE_CYCLES. FSM outputs update at edge E+2+DEBOUNCE_CYCLES.
- Glitch rejection: any raw pulse that holds in s2 for fewer than DEBOUNCE_CYCLES cycles produces no event.
- FSM (registered outputs, `en` = 1 exactly in RUN and STEP):
  - STOP: run press → RUN. Step press (no run press) → STEP. Run+step in same cycle → RUN.
  - RUN: run press → STOP. Step press ignored.
  - STEP: unconditionally → STOP next edge, so `en` is high exactly 1 cycle. Run/step presses arriving in STEP are dropped.
- Direction: a dir press toggles `up_down` on the next edge, in any state.
  - Run/step and dir presses in the same cycle both take effect.
- `state`: value 3 is unreachable. If entered, go to STOP next edge.

Optional Feature:
- Macro: `COUNT_CTRL_AUTO_REVERSE_EN`.
- Defined:
  - `en`=1 & `up_down`=1 & `overflow`=1 → `up_down` ← 0 next edge.
  - `en`=1 & `up_down`=0 & `underflow`=1 → `up_down` ← 1 next edge.
  - Auto-reverse has priority: a dir press in the same cycle is discarded.
  - FSM state unaffected.
- Undefined: `overflow`/`underflow` ports are present but ignored. `up_down` changes only on dir presses.

Test Plan:
- Reset check: `rst`=1 for 2 cycles with all buttons high → `en`=0, `up_down`=1, `state`=0 throughout. After release, run press held 10 cycles → `en`=1 exactly 6 edges after the first sampled-high edge (DEBOUNCE_CYCLES=4).
- Glitch rejection: `btn_run` pulses high 2 cycles, then 3 cycles → `en` stays 0, `state`=0. Hold 8 cycles → `state`=1. Second clean press → `state`=0, `en`=0.
- Single step: step press from STOP → `en`=1 for exactly 1 cycle, `state` 0→2→0. Step press while RUN → no change.
- Simultaneous presses:
  - Run and step raw edges identical from STOP → `state`=1.
  - Dir toggled together with run → `up_down`=0 and `en`=1 on the same edge.
  - Dir press while `rst` asserted mid-debounce → no toggle after reset release.
- Auto-reverse, with macro defined: RUN, `up_down`=1, `overflow` pulsed 1 cycle → `up_down`=0 next edge. Then `underflow` pulsed together with a dir press event → `up_down`=1 and the dir press is discarded.
- Auto-reverse, macro undefined: same stimulus → `up_down` unchanged by flags, dir press toggles normally.
